led_shift_tx: RTL and testbench
===============================

LED_SHIFT_TX -- requirements
Module: led_shift_tx

Interface
REQ-001 Parameter DATA_BITS, default 16: width of the parallel word shifted out per transfer.
REQ-002 Parameter DATA_COUNT_BITS, default 4: bit-counter width, with 2^DATA_COUNT_BITS >= DATA_BITS.
REQ-003 Parameter HALF_PERIOD, default 2: clk cycles per s_clk half period, with a minimum of 1.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 Start  input  1  transfer request; a rising edge is the request.
REQ-007 P_Data  input  DATA_BITS  parallel word, already polarity/order-adjusted by the I/O register stage.
REQ-008 s_clk  output  1  serial shift clock to the external shift-register chain.
REQ-009 sout  output  1  serial data, MSB first.
REQ-010 s_clrn  output  1  active-low clear to the external chain.
REQ-011 s_pen  output  1  storage-register latch enable to the external chain.
REQ-012 busy  output  1  high while a transfer is in progress.
REQ-013 done  output  1  one-cycle pulse at transfer completion.

Function
REQ-014 Start shall be registered each cycle; a request is Start=1 while the previous sample=0.
REQ-015 FSM states shall be IDLE, SHIFT, LATCH.
REQ-016 IDLE shall hold s_clk=0, s_pen=0, busy=0 and sout=0.
REQ-017 A request in IDLE shall capture P_Data into the shift register, clear the bit and phase counters, and enter SHIFT; busy=1 from the next cycle.
REQ-018 Requests while busy=1 shall be ignored and not queued; the captured word shall not change.
REQ-019 In SHIFT, each bit shall occupy 2*HALF_PERIOD cycles: HALF_PERIOD with s_clk=0, then HALF_PERIOD with s_clk=1.
REQ-020 sout shall equal the shift-register MSB and shall be stable for the whole bit period, so it is valid at every s_clk rising edge.
REQ-021 At the last cycle of each high phase, the shift register shall shift left by one (zero fill) and the bit counter shall increment.
REQ-022 When the bit counter equals DATA_BITS-1 at that point, the next state shall be LATCH; s_clk returns to 0.
REQ-023 LATCH shall drive s_pen=1 for exactly HALF_PERIOD cycles with s_clk=0, then return to IDLE.
REQ-024 On the LATCH-to-IDLE transition, done shall pulse for 1 cycle and busy shall fall in the same cycle.
REQ-025 busy shall be high for exactly DATA_BITS*2*HALF_PERIOD + HALF_PERIOD cycles per transfer.
REQ-026 A request arriving in the same cycle as done shall be accepted and start the next transfer.
REQ-027 Exactly DATA_BITS s_clk rising edges shall occur per transfer.
REQ-028 All outputs shall be registered, with no combinational path from inputs to outputs.

Reset
REQ-029 While rst=1: state=IDLE, counters=0, shift register=0, s_clk=0, sout=0, s_pen=0, busy=0, done=0, s_clrn=0.
REQ-030 s_clrn shall go to 1 on the first clk rising edge after rst deasserts.
REQ-031 The Start sample register shall reset to 1, so Start held high across reset release does not trigger a transfer.
REQ-032 rst asserted mid-transfer shall abort immediately with no s_pen pulse; s_clrn=0 clears the external chain.

Structure
REQ-033 A shared package shall hold the FSM state encoding and the default DATA_BITS, DATA_COUNT_BITS and HALF_PERIOD values.
REQ-034 One sub-module, led_shift_phase, shall generate the half-period phase tick and the s_clk level from an enable; the FSM and datapath shall live in led_shift_tx.

Verification (DATA_BITS=16, HALF_PERIOD=2)
REQ-035 Test: P_Data=16'hA5C3, Start 0->1 -> sout at the 16 s_clk rises = 1010_0101_1100_0011; busy high 66 cycles; s_pen high 2 cycles; done 1 cycle.
REQ-036 Test: Start pulsed again at cycles 10 and 40 of a transfer, with P_Data changed to 16'hFFFF -> original word shifted unchanged; no second transfer.
REQ-037 Test: Start held high through rst release -> no transfer and s_clrn=1 after 1 cycle; Start 0 then 1 -> transfer runs.
REQ-038 Test: rst asserted at cycle 20 of a transfer -> s_clrn=0 and busy=0 immediately; s_pen never asserted.
REQ-039 Test: a new request in the done cycle with P_Data=16'h0001 -> back-to-back transfer; 15 zeros then a 1 on sout.
REQ-040 Test: HALF_PERIOD=1, P_Data=16'h8000 -> s_clk toggles every cycle; busy high 33 cycles.

Source files
------------

// File: rtl/led_shift_tx_pkg.sv
// Shared FSM encoding and default sizing for the LED shift-register transmitter.
// No logic, no latency, no flow control; types and constants only.
// Importers override the defaults through their own parameters.
package led_shift_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    localparam int DEF_DATA_BITS       = 16;
    localparam int DEF_DATA_COUNT_BITS = 4;
    localparam int DEF_HALF_PERIOD     = 2;

endpackage

// File: rtl/led_shift_phase.sv
// Half-period timer: tick marks the last cycle of each half period, s_clk toggles on it.
// Latency: s_clk changes one cycle after the tick cycle; tick is valid while en is high.
// No backpressure; dropping en parks the counter and s_clk at zero.
module led_shift_phase
    import led_shift_tx_pkg::*;
#(
    parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic lvl_en,
    output logic tick,
    output logic s_clk
);

    localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            s_clk <= 1'b0;
        end else if (!en) begin
            cnt   <= '0;
            s_clk <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            // Level only toggles while shifting; the latch window stays low.
            s_clk <= lvl_en ? ~s_clk : 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_shift_tx.sv
// Serialises one DATA_BITS word MSB-first to an external shift-register chain, then latches it.
// Latency: busy rises 1 cycle after the Start edge; done pulses DATA_BITS*2*HALF_PERIOD+HALF_PERIOD cycles later.
// No backpressure; requests arriving while busy are dropped, not queued.
module led_shift_tx
    import led_shift_tx_pkg::*;
#(
    parameter int DATA_BITS       = DEF_DATA_BITS,
    parameter int DATA_COUNT_BITS = DEF_DATA_COUNT_BITS,
    parameter int HALF_PERIOD     = DEF_HALF_PERIOD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Start,
    input  logic [DATA_BITS-1:0] P_Data,
    output logic                 s_clk,
    output logic                 sout,
    output logic                 s_clrn,
    output logic                 s_pen,
    output logic                 busy,
    output logic                 done
);

    localparam logic [DATA_COUNT_BITS-1:0] LAST_BIT = DATA_COUNT_BITS'(DATA_BITS - 1);

    state_t                     state;
    state_t                     state_nxt;
    logic                       start_q;
    logic                       req;
    logic                       load;
    logic                       shift_en;
    logic                       ph_tick;
    logic [DATA_BITS-1:0]       shreg;
    logic [DATA_COUNT_BITS-1:0] bit_cnt;

    // start_q resets high so a Start held across reset release is not an edge.
    assign req  = Start && !start_q;
    assign sout = shreg[DATA_BITS-1];

    led_shift_phase #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_phase (
        .clk    (clk),
        .rst    (rst),
        .en     (state != ST_IDLE),
        .lvl_en (state == ST_SHIFT),
        .tick   (ph_tick),
        .s_clk  (s_clk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_SHIFT;
                    load      = 1'b1;
                end
            end
            ST_SHIFT: begin
                // Advance at the end of the high phase so sout holds across the rising edge.
                if (ph_tick && s_clk) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = ST_LATCH;
                    end
                end
            end
            ST_LATCH: begin
                if (ph_tick) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b1;
            shreg   <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
            s_pen   <= 1'b0;
            done    <= 1'b0;
            s_clrn  <= 1'b0;
        end else begin
            start_q <= Start;
            s_clrn  <= 1'b1;
            busy    <= (state_nxt != ST_IDLE);
            s_pen   <= (state_nxt == ST_LATCH);
            done    <= (state == ST_LATCH) && (state_nxt == ST_IDLE);
            if (load) begin
                shreg   <= P_Data;
                bit_cnt <= '0;
            end else if (shift_en) begin
                shreg   <= {shreg[DATA_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + DATA_COUNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_led_shift_tx.sv
// Scoreboarded bench: instance 0 runs HALF_PERIOD=2, instance 1 runs HALF_PERIOD=1.
module tb_led_shift_tx;

    typedef struct {
        int          id;
        logic [15:0] word;
        int          blen;
        int          plen;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start_w [2];
    logic [15:0] pdat_w  [2];
    logic        s_clk_w [2];
    logic        sout_w  [2];
    logic        s_clrn_w[2];
    logic        s_pen_w [2];
    logic        busy_w  [2];
    logic        done_w  [2];

    exp_t exp_q[$];
    int   applied = 0;
    int   errs    = 0;

    led_shift_tx #(.DATA_BITS(16), .DATA_COUNT_BITS(4), .HALF_PERIOD(2)) u_dut0 (
        .clk(clk), .rst(rst), .Start(start_w[0]), .P_Data(pdat_w[0]),
        .s_clk(s_clk_w[0]), .sout(sout_w[0]), .s_clrn(s_clrn_w[0]),
        .s_pen(s_pen_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    led_shift_tx #(.DATA_BITS(16), .DATA_COUNT_BITS(4), .HALF_PERIOD(1)) u_dut1 (
        .clk(clk), .rst(rst), .Start(start_w[1]), .P_Data(pdat_w[1]),
        .s_clk(s_clk_w[1]), .sout(sout_w[1]), .s_clrn(s_clrn_w[1]),
        .s_pen(s_pen_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitors: collect sout at each s_clk rise, measure busy/s_pen widths, score on done.
    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic [15:0] cap;
        int          rises, blen, plen;
        int          done_cnt  = 0;
        int          pen_total = 0;
        logic        prev_clk, prev_done;
        exp_t        e;

        always @(negedge clk) begin
            if (rst) begin
                cap = '0; rises = 0; blen = 0; plen = 0;
                prev_clk = 1'b0; prev_done = 1'b0;
            end else begin
                if (s_clk_w[g] && !prev_clk) begin
                    cap = {cap[14:0], sout_w[g]};
                    rises++;
                end
                if (busy_w[g]) blen++;
                if (s_pen_w[g]) begin
                    plen++;
                    pen_total++;
                end
                if (done_w[g] && prev_done) chk("done_width", 2, 1);
                if (done_w[g]) begin
                    done_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("done_with_empty_queue", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dut_id", g, e.id);
                        chk("word", {16'h0, cap}, {16'h0, e.word});
                        chk("s_clk_rises", rises, 16);
                        chk("busy_len", blen, e.blen);
                        chk("s_pen_len", plen, e.plen);
                    end
                    cap = '0; rises = 0; blen = 0; plen = 0;
                end
                prev_clk  = s_clk_w[g];
                prev_done = done_w[g];
            end
        end
    end

    function automatic int dcnt(input int g);
        return (g == 0) ? g_mon[0].done_cnt : g_mon[1].done_cnt;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int g, input logic [15:0] w, input bit push, input int bl, input int pl);
        exp_t e;
        if (push) begin
            e.id = g; e.word = w; e.blen = bl; e.plen = pl;
            exp_q.push_back(e);
        end
        pdat_w[g]  = w;
        start_w[g] = 1'b1;
        cyc(1);
        start_w[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int target);
        int n = 0;
        while (dcnt(g) < target && n < 300) begin
            cyc(1);
            n++;
        end
        chk("done_seen_in_time", dcnt(g) >= target, 1);
    endtask

    task automatic run(input int g, input logic [15:0] w, input int bl, input int pl);
        int t = dcnt(g) + 1;
        xfer(g, w, 1'b1, bl, pl);
        wait_done(g, t);
    endtask

    initial begin
        int c, p, n;
        rst = 1'b1;
        start_w[0] = 1'b0; start_w[1] = 1'b0;
        pdat_w[0]  = '0;   pdat_w[1]  = '0;
        cyc(3);
        chk("rst_s_clrn", s_clrn_w[0], 0);
        chk("rst_busy",   busy_w[0],   0);
        chk("rst_s_clk",  s_clk_w[0],  0);
        chk("rst_sout",   sout_w[0],   0);
        chk("rst_s_pen",  s_pen_w[0],  0);
        chk("rst_done",   done_w[0],   0);
        rst = 1'b0;
        #1;
        chk("s_clrn_before_edge", s_clrn_w[0], 0);
        cyc(1);
        chk("s_clrn_after_edge", s_clrn_w[0], 1);
        cyc(2);

        // Basic word, 66-cycle busy, 2-cycle latch.
        run(0, 16'hA5C3, 66, 2);
        cyc(3);

        // Re-requests mid-transfer with a new word are ignored.
        c = dcnt(0);
        xfer(0, 16'h1234, 1'b1, 66, 2);
        cyc(8);
        pdat_w[0] = 16'hFFFF; start_w[0] = 1'b1; cyc(1); start_w[0] = 1'b0;
        cyc(29);
        start_w[0] = 1'b1; cyc(1); start_w[0] = 1'b0;
        wait_done(0, c + 1);
        cyc(100);
        chk("no_second_xfer", dcnt(0) - c, 1);
        chk("idle_after_ignored_req", busy_w[0], 0);

        // Start held high through reset release.
        rst = 1'b1; start_w[0] = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk("s_clrn_one_cycle_after_rst", s_clrn_w[0], 1);
        c = dcnt(0);
        cyc(20);
        chk("held_start_no_busy", busy_w[0], 0);
        chk("held_start_no_done", dcnt(0) - c, 0);
        start_w[0] = 1'b0;
        cyc(1);
        run(0, 16'h5A0F, 66, 2);
        cyc(3);

        // Reset mid-transfer aborts with no latch pulse.
        c = dcnt(0);
        p = g_mon[0].pen_total;
        xfer(0, 16'hFFFF, 1'b0, 0, 0);
        cyc(19);
        chk("midxfer_busy", busy_w[0], 1);
        rst = 1'b1;
        #1;
        chk("abort_s_clrn", s_clrn_w[0], 0);
        chk("abort_busy",   busy_w[0],   0);
        chk("abort_s_clk",  s_clk_w[0],  0);
        chk("abort_sout",   sout_w[0],   0);
        cyc(2);
        rst = 1'b0;
        cyc(80);
        chk("abort_no_s_pen", g_mon[0].pen_total - p, 0);
        chk("abort_no_done",  dcnt(0) - c, 0);

        // Back-to-back: new request issued in the done cycle.
        c = dcnt(0);
        xfer(0, 16'hC3A5, 1'b1, 66, 2);
        n = 0;
        while (!done_w[0] && n < 300) begin
            cyc(1);
            n++;
        end
        chk("b2b_first_done", done_w[0], 1);
        xfer(0, 16'h0001, 1'b1, 66, 2);
        chk("b2b_busy_restart", busy_w[0], 1);
        wait_done(0, c + 2);
        cyc(3);

        // HALF_PERIOD=1 instance: s_clk toggles every cycle, 33-cycle busy.
        run(1, 16'h8000, 33, 1);
        cyc(3);

        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
